// File: rtl/score_pulse_if.sv
// Hit-strobe inputs and point-pulse outputs of the score pulse generator.
// The master drives hits and game_reset; the slave returns the pulse and status.
interface score_pulse_if #(
    parameter int PEND_W = 4
);
    logic              hit_valid;
    logic [1:0]        hit_points;
    logic              game_reset;
    logic              score_toggle;
    logic [PEND_W-1:0] pending;
    logic              busy;
    logic              overflow;

    modport master (
        output hit_valid, hit_points, game_reset,
        input  score_toggle, pending, busy, overflow
    );

    modport slave (
        input  hit_valid, hit_points, game_reset,
        output score_toggle, pending, busy, overflow
    );
endinterface

// File: rtl/score_pulse_gen.sv
// Banks hit points and replays each one as a single clean pulse on score_toggle,
// with guaranteed minimum high and low widths for the downstream BCD counter.
module score_pulse_gen #(
    parameter int PULSE_HIGH = 4,
    parameter int PULSE_LOW  = 4,
    parameter int PEND_W     = 4
) (
    input  logic         clk,
    input  logic         resetn,
    score_pulse_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [7:0]        HIGH_LOAD = 8'(PULSE_HIGH - 1);
    localparam logic [7:0]        LOW_LOAD  = 8'(PULSE_LOW - 1);
    localparam logic [PEND_W+1:0] PEND_MAX  = {2'b00, {PEND_W{1'b1}}};

    state_t            state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              tog_q;
    logic              dec;
    logic [PEND_W+1:0] sum;

    function automatic logic [PEND_W-1:0] sat_pend(input logic [PEND_W+1:0] s);
        if (s > PEND_MAX) begin
            return {PEND_W{1'b1}};
        end
        return s[PEND_W-1:0];
    endfunction

    // tog_q mirrors "next state is HIGH" so the pulse leaves a flop, glitch-free
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            tog_q   <= (state_d == HIGH);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.game_reset && pend_q != '0) begin
                    state_d = HIGH;
                    timer_d = HIGH_LOAD;
                    dec     = 1'b1;
                end
            end
            HIGH: begin
                // game_reset cuts the pulse short but still enforces the full low time
                if (bus.game_reset || timer_q == 8'd0) begin
                    state_d = LOW;
                    timer_d = LOW_LOAD;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            LOW: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else if (!bus.game_reset && pend_q != '0) begin
                    state_d = HIGH;
                    timer_d = HIGH_LOAD;
                    dec     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Hits are added in the same cycle a point is consumed, so none can be lost
    always_comb begin
        sum = {2'b00, pend_q}
            + {{PEND_W{1'b0}}, (bus.hit_valid ? bus.hit_points : 2'b00)}
            - {{(PEND_W+1){1'b0}}, dec};
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (bus.game_reset) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else begin
            pend_d = sat_pend(sum);
            if (sum > PEND_MAX) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.score_toggle = tog_q;
        bus.pending      = pend_q;
        bus.busy         = (state_q != IDLE);
        bus.overflow     = ovf_q;
    end
endmodule
